// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps an NVARS-bit vector through every combination,
// drives it onto a 3-input SoP/PoS pair, captures both truth tables and
// compares them against the EXPECT minterm mask.
// Optional build macro SWEEP_STOP_ON_FAIL_EN: end the sweep on the first
// failing vector, keeping that vector's results.
module truth_table_sweeper #(
  parameter int                      NVARS  = 3,
  parameter logic [(1<<NVARS)-1:0]   EXPECT = 8'hD5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sop_in,
  input  logic                      pos_in,
  output logic [NVARS-1:0]          vec,
  output logic                      busy,
  output logic                      done,
  output logic [(1<<NVARS)-1:0]     table_sop,
  output logic [(1<<NVARS)-1:0]     table_pos,
  output logic                      mismatch,
  output logic [NVARS:0]            fail_count,
  output logic [NVARS-1:0]          first_fail
);

  localparam int                TW   = 1 << NVARS;
  localparam logic [NVARS-1:0]  LAST = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t              state_q;
  logic [NVARS-1:0]    vec_q;
  logic                busy_q, done_q, mismatch_q;
  logic [TW-1:0]       table_sop_q, table_pos_q;
  logic [NVARS:0]      fail_count_q;
  logic [NVARS-1:0]    first_fail_q;

  logic                fail_d;
  logic                finish_d;

  // Per-sample verdict and whether this sample ends the sweep.
  always_comb begin
    fail_d   = (sop_in != EXPECT[vec_q]) || (pos_in != EXPECT[vec_q]);
    finish_d = (vec_q == LAST);
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (fail_d) finish_d = 1'b1;
`endif
  end

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      table_sop_q  <= '0;
      table_pos_q  <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      case (state_q)
        // IDLE and DONE both accept start; DONE holds results until then.
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            vec_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            table_sop_q  <= '0;
            table_pos_q  <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
          end
        end
        // One settle cycle for the downstream combinational pair.
        DRIVE: state_q <= SAMPLE;
        SAMPLE: begin
          table_sop_q[vec_q] <= sop_in;
          table_pos_q[vec_q] <= pos_in;
          if (fail_d) begin
            fail_count_q <= fail_count_q + (NVARS+1)'(1);
            mismatch_q   <= 1'b1;
            if (!mismatch_q) first_fail_q <= vec_q;
          end
          if (finish_d) begin
            // vec holds its last value; no wrap.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            vec_q   <= vec_q + NVARS'(1);
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_sop  = table_sop_q;
  assign table_pos  = table_pos_q;
  assign mismatch   = mismatch_q;
  assign fail_count = fail_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (NVARS=3, EXPECT=8'hD5).
// Cycle n means "just after rising edge n", where edge 0 samples start.
module tb_truth_table_sweeper;

  localparam logic [7:0] EXP_TT = 8'hD5;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       sop_in, pos_in;
  logic [2:0] vec;
  logic       busy, done, mismatch;
  logic [7:0] table_sop, table_pos;
  logic [3:0] fail_count;
  logic [2:0] first_fail;

  int mode;   // 0: correct pair, 1: PoS wrong at vector 5, 2: SoP stuck at 0
  int passed = 0;
  int total  = 0;

  truth_table_sweeper dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sop_in     (sop_in),
    .pos_in     (pos_in),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .table_sop  (table_sop),
    .table_pos  (table_pos),
    .mismatch   (mismatch),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream SoP/PoS pair.
  always_comb begin
    sop_in = EXP_TT[vec];
    pos_in = EXP_TT[vec];
    if (mode == 1 && vec == 3'd5) pos_in = ~EXP_TT[vec];
    if (mode == 2) sop_in = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for edge 0, then count cycles until done (bounded).
  task automatic run_sweep(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 0;
    tick(); tick();
    total++;
    if ({vec, busy, done, mismatch, fail_count, first_fail} !== 13'd0) begin
      $display("FAIL reset_ctrl: got vec=%0d busy=%0b done=%0b mm=%0b fc=%0d ff=%0d expected all 0",
               vec, busy, done, mismatch, fail_count, first_fail);
    end else passed++;
    total++;
    if ({table_sop, table_pos} !== 16'h0) begin
      $display("FAIL reset_tables: got sop=%h pos=%h expected 00/00", table_sop, table_pos);
    end else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_correct_sweep();
    int seq_err = 0;
    int busy_err = 0;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (vec !== 3'((c - 1) / 2)) seq_err++;
      if (busy !== 1'b1 || done !== 1'b0) busy_err++;
      if (c < 16) tick();
    end
    total++;
    if (seq_err != 0) $display("FAIL vec_sequence: got %0d bad cycles expected 0", seq_err);
    else passed++;
    total++;
    if (busy_err != 0) $display("FAIL busy_window: got %0d bad cycles expected 0", busy_err);
    else passed++;
    tick();  // cycle 17
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL done_at_17: got done=%0b busy=%0b expected 1/0", done, busy);
    end else passed++;
    total++;
    if (vec !== 3'd7) $display("FAIL vec_hold: got %0d expected 7", vec);
    else passed++;
    total++;
    if (table_sop !== 8'hD5 || table_pos !== 8'hD5) begin
      $display("FAIL good_tables: got sop=%h pos=%h expected d5/d5", table_sop, table_pos);
    end else passed++;
    total++;
    if (mismatch !== 1'b0 || fail_count !== 4'd0 || first_fail !== 3'd0) begin
      $display("FAIL good_verdict: got mm=%0b fc=%0d ff=%0d expected 0/0/0",
               mismatch, fail_count, first_fail);
    end else passed++;
    tick(); tick();
    total++;
    if (done !== 1'b1 || table_sop !== 8'hD5) begin
      $display("FAIL done_hold: got done=%0b sop=%h expected 1/d5", done, table_sop);
    end else passed++;
  endtask

  task automatic test_pos_fault();
    int cyc;
`ifdef SWEEP_STOP_ON_FAIL_EN
    int exp_cyc = 13; logic [7:0] exp_sop = 8'h15, exp_pos = 8'h35;
`else
    int exp_cyc = 17; logic [7:0] exp_sop = 8'hD5, exp_pos = 8'hF5;
`endif
    mode = 1;
    run_sweep(cyc);
    total++;
    if (cyc != exp_cyc) $display("FAIL pos_done_cycle: got %0d expected %0d", cyc, exp_cyc);
    else passed++;
    total++;
    if (table_sop !== exp_sop || table_pos !== exp_pos) begin
      $display("FAIL pos_tables: got sop=%h pos=%h expected %h/%h", table_sop, table_pos, exp_sop, exp_pos);
    end else passed++;
    total++;
    if (mismatch !== 1'b1 || fail_count !== 4'd1 || first_fail !== 3'd5) begin
      $display("FAIL pos_verdict: got mm=%0b fc=%0d ff=%0d expected 1/1/5",
               mismatch, fail_count, first_fail);
    end else passed++;
    tick();
  endtask

  task automatic test_sop_zero();
    int cyc;
`ifdef SWEEP_STOP_ON_FAIL_EN
    int exp_cyc = 3; logic [7:0] exp_pos = 8'h01; logic [3:0] exp_fc = 4'd1; logic [2:0] exp_vec = 3'd0;
`else
    int exp_cyc = 17; logic [7:0] exp_pos = 8'hD5; logic [3:0] exp_fc = 4'd5; logic [2:0] exp_vec = 3'd7;
`endif
    mode = 2;
    run_sweep(cyc);
    total++;
    if (cyc != exp_cyc) $display("FAIL sop0_done_cycle: got %0d expected %0d", cyc, exp_cyc);
    else passed++;
    total++;
    if (table_sop !== 8'h00 || table_pos !== exp_pos) begin
      $display("FAIL sop0_tables: got sop=%h pos=%h expected 00/%h", table_sop, table_pos, exp_pos);
    end else passed++;
    total++;
    if (mismatch !== 1'b1 || fail_count !== exp_fc || first_fail !== 3'd0) begin
      $display("FAIL sop0_verdict: got mm=%0b fc=%0d ff=%0d expected 1/%0d/0",
               mismatch, fail_count, first_fail, exp_fc);
    end else passed++;
    total++;
    if (vec !== exp_vec) $display("FAIL sop0_vec: got %0d expected %0d", vec, exp_vec);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();  // cycle 7
    total++;
    if (busy !== 1'b1 || table_sop !== 8'h05 || vec !== 3'd3) begin
      $display("FAIL mid_progress: got busy=%0b sop=%h vec=%0d expected 1/05/3", busy, table_sop, vec);
    end else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({vec, busy, done, mismatch, fail_count, first_fail, table_sop, table_pos} !== 29'd0) begin
      $display("FAIL mid_reset_clear: got vec=%0d busy=%0b done=%0b sop=%h pos=%h expected all 0",
               vec, busy, done, table_sop, table_pos);
    end else passed++;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL mid_reset_idle: got busy=%0b done=%0b expected 0/0", busy, done);
    end else passed++;
    run_sweep(cyc);
    total++;
    if (cyc != 17 || table_sop !== 8'hD5 || table_pos !== 8'hD5 || mismatch !== 1'b0) begin
      $display("FAIL post_reset_sweep: got cyc=%0d sop=%h pos=%h mm=%0b expected 17/d5/d5/0",
               cyc, table_sop, table_pos, mismatch);
    end else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
`ifdef SWEEP_STOP_ON_FAIL_EN
    int exp_cyc = 13;
`else
    int exp_cyc = 17;
`endif
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      start = (cyc == 4 || cyc == 9);
      tick();
      start = 1'b0;
      cyc++;
    end
    total++;
    if (cyc != exp_cyc) $display("FAIL busy_start_ignored: got done at %0d expected %0d", cyc, exp_cyc);
    else passed++;
    // Restart from DONE with start held high for the whole sweep.
    mode = 0;
    start = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || vec !== 3'd0) begin
      $display("FAIL restart_ctrl: got done=%0b busy=%0b vec=%0d expected 0/1/0", done, busy, vec);
    end else passed++;
    total++;
    if ({table_sop, table_pos, mismatch, fail_count, first_fail} !== 24'd0) begin
      $display("FAIL restart_clear: got sop=%h pos=%h mm=%0b fc=%0d ff=%0d expected all 0",
               table_sop, table_pos, mismatch, fail_count, first_fail);
    end else passed++;
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 17 || table_sop !== 8'hD5) begin
      $display("FAIL held_start_sweep: got cyc=%0d sop=%h expected 17/d5", cyc, table_sop);
    end else passed++;
    tick();  // start still high: one restart per DONE visit
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL held_start_restart: got done=%0b busy=%0b expected 0/1", done, busy);
    end else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_sweep();
    test_pos_fault();
    test_sop_zero();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus generator and checker that sits directly upstream of the 3-input sum-of-products / product-of-sums pair.
- Steps an N-bit input vector through all 2^N combinations and drives each one onto the pair's x/y/z inputs.
- Samples both function outputs, assembles the captured truth tables and compares them against an expected minterm mask.
- Reports pass/fail through a start/busy/done handshake.

Parameters:
- NVARS, 3, number of input variables; vector width; table width is 2^NVARS.
- EXPECT, 8'hD5, expected minterm mask. Bit i is the required output for vector i; the default is minterms 0,2,4,6,7.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE or DONE
- sop_in  input  1  output of the SoP block (combinational from vec)
- pos_in  input  1  output of the PoS block (combinational from vec)
- vec  output  NVARS  current input vector; bit NVARS-1 = x, bit 0 = z
- busy  output  1  high while the sweep runs
- done  output  1  high in DONE; held until the next start or reset
- table_sop  output  2^NVARS  captured SoP truth table; bit i holds the result for vector i
- table_pos  output  2^NVARS  captured PoS truth table
- mismatch  output  1  sticky; set when any sample differs from EXPECT
- fail_count  output  NVARS+1  number of failing vectors
- first_fail  output  NVARS  index of the first failing vector; 0 if none

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-sweep aborts the sweep; no partial results are kept.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1:
  - Clear table_sop, table_pos, mismatch, fail_count and first_fail.
  - vec <= 0, busy <= 1, go to DRIVE.
- DRIVE: vec stable; the downstream logic settles. Go to SAMPLE next cycle.
- SAMPLE:
  - table_sop[vec] <= sop_in; table_pos[vec] <= pos_in.
  - The vector fails if sop_in != EXPECT[vec] or pos_in != EXPECT[vec].
  - On a fail: fail_count increments and mismatch <= 1. If mismatch was 0 before this sample, first_fail <= vec.
  - If vec == 2^NVARS-1: go to DONE, busy <= 0, done <= 1. vec holds its last value.
  - Otherwise: vec <= vec+1 and go to DRIVE.
- DONE:
  - Results are held stable.
  - start=1: clears done, then behaves exactly like start in IDLE (restart).
- Timing: start seen at edge 0 → DRIVE vec=0 at cycle 1 → SAMPLE at cycle 2. The last SAMPLE is at cycle 2·2^NVARS. done rises at cycle 2·2^NVARS+1, which is 17 for the default NVARS=3.
- start while busy is ignored. start held high continuously from DONE restarts once per DONE visit.
- vec never wraps during a sweep; the final increment is suppressed.
- fail_count is wide enough for 2^NVARS failures without overflow.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: on the first failing SAMPLE, go directly to DONE.
  - vec, the tables and the counters freeze with that vector's results already captured.
  - fail_count = 1.
- Undefined: always sweep every vector, as specified above.

Test Plan:
- Correct pair, sop_in = pos_in = EXPECT[vec], start pulse → done at cycle 17, table_sop = table_pos = 8'hD5, mismatch=0, fail_count=0, first_fail=0.
- Model pos_in = EXPECT[vec] ^ (vec==5) → table_pos=8'hF5, table_sop=8'hD5, mismatch=1, fail_count=1, first_fail=5.
- Model sop_in = 0 for all vectors → table_sop=8'h00, fail_count=5, first_fail=0. With SWEEP_STOP_ON_FAIL_EN: done at cycle 3, vec=0, fail_count=1.
- Assert reset at cycle 7 mid-sweep → next cycle all outputs 0 in IDLE. A new start gives a full, clean 17-cycle sweep.
- start pulses at cycles 4 and 9 during the sweep → ignored, done still at 17. start in DONE → done falls next cycle, previous results cleared, vec=0.
- Check vec sequence over one sweep: 0,0,1,1,…,7,7 on cycles 1–16, and busy=1 exactly on cycles 1–16.
